// File: rtl/ask4_burst_source_if.sv
// ask4_burst_source_if: strobe/run controls and DAC-side outputs of the 4-ASK burst source.
interface ask4_burst_source_if;
    logic sam_clk_ena;
    logic sym_clk_ena;
    logic run;
    logic signed [17:0] sample_out;
    logic [1:0] symbol;
    logic sym_strobe;
    logic busy;
    logic phase_err;
    modport master (output sam_clk_ena, sym_clk_ena, run, input sample_out, symbol, sym_strobe, busy, phase_err);
    modport slave (input sam_clk_ena, sym_clk_ena, run, output sample_out, symbol, sym_strobe, busy, phase_err);
endinterface

// File: rtl/ask4_burst_source.sv
// ask4_burst_source: PRBS-driven 4-ASK burst generator (IDLE -> +-3a preamble -> payload), upsampled by 4.
module ask4_burst_source #(
    parameter logic signed [17:0] LEVEL_A = 18'sd32768,
    parameter int PREAMBLE_LEN = 8,
    parameter bit HOLD = 1'b0
) (
    input logic clock_50,
    input logic reset,
    ask4_burst_source_if.slave bus
);
    typedef enum logic [1:0] {IDLE, PREAMBLE, RUN} state_t;
    localparam logic [14:0] SEED = 15'h7FFF;
    localparam logic signed [17:0] LEVEL_3A = 18'sd3 * LEVEL_A;
    state_t state;
    logic [14:0] lfsr;
    logic [7:0] pre_cnt;
    logic signed [17:0] level;
    logic [1:0] prbs_sym;
    logic [1:0] next_sym;
    logic [14:0] lfsr_next;
    logic signed [17:0] next_level;
    logic payload;
    // Two LFSR shifts per symbol collapse to one step: bits are {q14^q13, q13^q12}.
    always_comb begin
        prbs_sym = {lfsr[14] ^ lfsr[13], lfsr[13] ^ lfsr[12]};
        lfsr_next = {lfsr[12:0], prbs_sym};
        payload = state == RUN || (state == PREAMBLE && pre_cnt == 8'(PREAMBLE_LEN));
        next_sym = payload ? prbs_sym : {~pre_cnt[0], 1'b0};
        next_level = next_sym[1] ? (next_sym[0] ? LEVEL_A : LEVEL_3A)
                                 : (next_sym[0] ? -LEVEL_A : -LEVEL_3A);
    end
    always_ff @(posedge clock_50) begin
        if (!reset) begin
            state <= IDLE;
            lfsr <= SEED;
            pre_cnt <= '0;
            level <= '0;
            bus.sample_out <= '0;
            bus.symbol <= 2'b00;
            bus.sym_strobe <= 1'b0;
            bus.busy <= 1'b0;
            bus.phase_err <= 1'b0;
        end else begin
            bus.sym_strobe <= 1'b0;
            if (bus.sym_clk_ena && !bus.sam_clk_ena) begin
                bus.phase_err <= 1'b1;
            end else if (bus.sym_clk_ena && !bus.run) begin
                state <= IDLE;
                lfsr <= SEED;
                pre_cnt <= '0;
                level <= '0;
                bus.sample_out <= '0;
                bus.busy <= 1'b0;
            end else if (bus.sym_clk_ena) begin
                state <= payload ? RUN : PREAMBLE;
                if (payload) lfsr <= lfsr_next;
                else pre_cnt <= pre_cnt + 8'd1;
                level <= next_level;
                bus.sample_out <= next_level;
                bus.symbol <= next_sym;
                bus.sym_strobe <= 1'b1;
                bus.busy <= 1'b1;
            end else if (bus.sam_clk_ena) begin
                bus.sample_out <= HOLD ? level : '0;
            end
        end
    end
endmodule

// File: tb/tb_ask4_burst_source.sv
// tb_ask4_burst_source: directed checks of two source instances (zero-stuff/len 8 and hold/len 1).
module tb_ask4_burst_source;
    logic clock_50 = 1'b0;
    logic reset;
    always #5 clock_50 = ~clock_50;
    ask4_burst_source_if bus0();
    ask4_burst_source_if bus1();
    ask4_burst_source #(.LEVEL_A(18'sd32768), .PREAMBLE_LEN(8), .HOLD(1'b0)) dut0 (
        .clock_50(clock_50), .reset(reset), .bus(bus0.slave));
    ask4_burst_source #(.LEVEL_A(18'sd32768), .PREAMBLE_LEN(1), .HOLD(1'b1)) dut1 (
        .clock_50(clock_50), .reset(reset), .bus(bus1.slave));
    localparam logic signed [17:0] P3 = 18'sd98304;
    localparam logic signed [17:0] M3 = -18'sd98304;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic csam;
    logic csym;
    logic [14:0] ref_q;
    // csam/csym record the strobes consumed by the edge just taken
    task automatic step();
        csam = bus0.sam_clk_ena;
        csym = bus0.sym_clk_ena;
        @(posedge clock_50);
        #1;
        cyc++;
        bus0.sam_clk_ena = (cyc % 4 == 0);
        bus0.sym_clk_ena = (cyc % 16 == 0);
        bus1.sam_clk_ena = bus0.sam_clk_ena;
        bus1.sym_clk_ena = bus0.sym_clk_ena;
    endtask
    task automatic wait_sym();
        int n = 0;
        do begin
            step();
            n++;
        end while (!(csym && csam) && n < 40);
        checks++;
        if (!(csym && csam)) begin
            errors++;
            $display("FAIL wait_sym: no symbol strobe within %0d cycles", n);
        end
    endtask
    task automatic wait_sam();
        int n = 0;
        do begin
            step();
            n++;
        end while (!csam && n < 8);
        checks++;
        if (!csam) begin
            errors++;
            $display("FAIL wait_sam: no sample strobe within %0d cycles", n);
        end
    endtask
    task automatic ref_step(output logic [1:0] s);
        logic nb;
        s = 2'b00;
        for (int i = 0; i < 2; i++) begin
            nb = ref_q[14] ^ ref_q[13];
            ref_q = {ref_q[13:0], nb};
            s = {s[0], nb};
        end
    endtask
    task automatic test_reset();
        int strobes = 0;
        int nonzero = 0;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) step();
        checks += 6;
        if (bus0.sample_out !== 18'sd0) begin errors++; $display("FAIL reset_sample: got %0d expected 0", bus0.sample_out); end
        if (bus0.symbol !== 2'b00) begin errors++; $display("FAIL reset_symbol: got %b expected 00", bus0.symbol); end
        if (bus0.sym_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe: got %b expected 0", bus0.sym_strobe); end
        if (bus0.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus0.busy); end
        if (bus0.phase_err !== 1'b0) begin errors++; $display("FAIL reset_phase_err: got %b expected 0", bus0.phase_err); end
        if (bus1.sample_out !== 18'sd0) begin errors++; $display("FAIL reset_sample_hold: got %0d expected 0", bus1.sample_out); end
        reset = 1'b1;
        for (int i = 0; i < 64; i++) begin
            step();
            if (bus0.sym_strobe !== 1'b0 || bus1.sym_strobe !== 1'b0) strobes++;
            if (bus0.sample_out !== 18'sd0 || bus1.sample_out !== 18'sd0) nonzero++;
        end
        checks += 2;
        if (strobes != 0) begin errors++; $display("FAIL idle_strobes: got %0d expected 0", strobes); end
        if (nonzero != 0) begin errors++; $display("FAIL idle_samples_nonzero: got %0d expected 0", nonzero); end
    endtask
    task automatic test_hold();
        logic signed [17:0] exp;
        logic [1:0] es;
        bus1.run = 1'b1;
        wait_sym();
        checks += 3;
        if (bus1.sym_strobe !== 1'b1) begin errors++; $display("FAIL hold_strobe: got %b expected 1", bus1.sym_strobe); end
        if (bus1.busy !== 1'b1) begin errors++; $display("FAIL hold_busy: got %b expected 1", bus1.busy); end
        if (bus1.symbol !== 2'b10) begin errors++; $display("FAIL hold_first_symbol: got %b expected 10", bus1.symbol); end
        for (int i = 0; i < 8; i++) begin
            if (i > 0) wait_sam();
            exp = (i < 4) ? P3 : M3;
            checks++;
            if (bus1.sample_out !== exp) begin errors++; $display("FAIL hold_sample[%0d]: got %0d expected %0d", i, bus1.sample_out, exp); end
        end
        for (int j = 2; j <= 8; j++) begin
            wait_sym();
            es = (j == 8) ? 2'b10 : 2'b00;
            checks++;
            if (bus1.symbol !== es) begin errors++; $display("FAIL hold_payload_symbol[%0d]: got %b expected %b", j, bus1.symbol, es); end
        end
        for (int i = 0; i < 4; i++) begin
            if (i > 0) wait_sam();
            checks++;
            if (bus1.sample_out !== P3) begin errors++; $display("FAIL hold_payload_sample[%0d]: got %0d expected %0d", i, bus1.sample_out, P3); end
        end
        bus1.run = 1'b0;
        wait_sym();
        checks += 3;
        if (bus1.busy !== 1'b0) begin errors++; $display("FAIL hold_stop_busy: got %b expected 0", bus1.busy); end
        if (bus1.sample_out !== 18'sd0) begin errors++; $display("FAIL hold_stop_sample: got %0d expected 0", bus1.sample_out); end
        if (bus1.sym_strobe !== 1'b0) begin errors++; $display("FAIL hold_stop_strobe: got %b expected 0", bus1.sym_strobe); end
        wait_sam();
        checks++;
        if (bus1.sample_out !== 18'sd0) begin errors++; $display("FAIL hold_idle_sample: got %0d expected 0", bus1.sample_out); end
    endtask
    task automatic test_preamble();
        logic signed [17:0] exp;
        logic [1:0] es;
        bus0.run = 1'b1;
        wait_sym();
        checks++;
        if (bus0.busy !== 1'b1) begin errors++; $display("FAIL pre_busy: got %b expected 1", bus0.busy); end
        for (int i = 0; i < 32; i++) begin
            if (i > 0) wait_sam();
            exp = (i % 4 != 0) ? 18'sd0 : (((i / 4) % 2 == 1) ? M3 : P3);
            checks++;
            if (bus0.sample_out !== exp) begin errors++; $display("FAIL pre_sample[%0d]: got %0d expected %0d", i, bus0.sample_out, exp); end
            if (i % 4 == 0) begin
                es = ((i / 4) % 2 == 1) ? 2'b00 : 2'b10;
                checks += 2;
                if (bus0.symbol !== es) begin errors++; $display("FAIL pre_symbol[%0d]: got %b expected %b", i / 4, bus0.symbol, es); end
                if (bus0.sym_strobe !== 1'b1) begin errors++; $display("FAIL pre_strobe[%0d]: got %b expected 1", i / 4, bus0.sym_strobe); end
            end
            if (i == 0) begin
                step();
                checks++;
                if (bus0.sym_strobe !== 1'b0) begin errors++; $display("FAIL pre_strobe_width: got %b expected 0", bus0.sym_strobe); end
            end
        end
    endtask
    task automatic test_payload();
        logic [1:0] s;
        logic [1:0] es;
        ref_q = 15'h7FFF;
        for (int j = 1; j <= 4096; j++) begin
            wait_sym();
            ref_step(s);
            checks++;
            if (bus0.symbol !== s) begin errors++; $display("FAIL payload_ref[%0d]: got %b expected %b", j, bus0.symbol, s); end
            if (j <= 8) begin
                es = (j == 8) ? 2'b10 : 2'b00;
                checks += 2;
                if (bus0.symbol !== es) begin errors++; $display("FAIL payload_hand[%0d]: got %b expected %b", j, bus0.symbol, es); end
                if (bus0.sample_out !== ((j == 8) ? P3 : M3)) begin errors++; $display("FAIL payload_sample[%0d]: got %0d expected %0d", j, bus0.sample_out, (j == 8) ? P3 : M3); end
            end
        end
        checks++;
        if (bus0.busy !== 1'b1) begin errors++; $display("FAIL payload_busy: got %b expected 1", bus0.busy); end
    endtask
    task automatic test_stop_restart();
        int cnt = 0;
        int nonzero = 0;
        logic [1:0] s;
        logic [1:0] es;
        step();
        step();
        bus0.run = 1'b0;
        wait_sym();
        checks += 3;
        if (bus0.busy !== 1'b0) begin errors++; $display("FAIL stop_busy: got %b expected 0", bus0.busy); end
        if (bus0.sample_out !== 18'sd0) begin errors++; $display("FAIL stop_sample: got %0d expected 0", bus0.sample_out); end
        if (bus0.sym_strobe !== 1'b0) begin errors++; $display("FAIL stop_strobe: got %b expected 0", bus0.sym_strobe); end
        for (int i = 0; i < 48; i++) begin
            step();
            if (bus0.sym_strobe !== 1'b0) cnt++;
            if (bus0.sample_out !== 18'sd0) nonzero++;
        end
        checks += 2;
        if (cnt != 0) begin errors++; $display("FAIL stop_no_strobes: got %0d expected 0", cnt); end
        if (nonzero != 0) begin errors++; $display("FAIL stop_samples_zero: got %0d expected 0", nonzero); end
        bus0.run = 1'b1;
        wait_sym();
        checks += 3;
        if (bus0.symbol !== 2'b10) begin errors++; $display("FAIL restart_symbol: got %b expected 10", bus0.symbol); end
        if (bus0.sample_out !== P3) begin errors++; $display("FAIL restart_sample: got %0d expected %0d", bus0.sample_out, P3); end
        if (bus0.busy !== 1'b1) begin errors++; $display("FAIL restart_busy: got %b expected 1", bus0.busy); end
        for (int i = 0; i < 7; i++) wait_sym();
        ref_q = 15'h7FFF;
        for (int j = 1; j <= 8; j++) begin
            wait_sym();
            ref_step(s);
            es = (j == 8) ? 2'b10 : 2'b00;
            checks++;
            if (bus0.symbol !== es) begin errors++; $display("FAIL restart_payload[%0d]: got %b expected %b", j, bus0.symbol, es); end
        end
    endtask
    task automatic test_strobe_fault();
        logic [1:0] s;
        bus0.sym_clk_ena = 1'b1;
        bus0.sam_clk_ena = 1'b0;
        step();
        checks += 3;
        if (bus0.phase_err !== 1'b1) begin errors++; $display("FAIL fault_phase_err: got %b expected 1", bus0.phase_err); end
        if (bus0.sym_strobe !== 1'b0) begin errors++; $display("FAIL fault_strobe: got %b expected 0", bus0.sym_strobe); end
        if (bus0.symbol !== 2'b10) begin errors++; $display("FAIL fault_symbol_held: got %b expected 10", bus0.symbol); end
        for (int j = 9; j <= 11; j++) begin
            wait_sym();
            ref_step(s);
            checks++;
            if (bus0.symbol !== s) begin errors++; $display("FAIL fault_continue[%0d]: got %b expected %b", j, bus0.symbol, s); end
        end
        checks++;
        if (bus0.phase_err !== 1'b1) begin errors++; $display("FAIL fault_sticky: got %b expected 1", bus0.phase_err); end
    endtask
    task automatic test_reset_mid_burst();
        step();
        step();
        step();
        reset = 1'b0;
        step();
        checks += 5;
        if (bus0.sample_out !== 18'sd0) begin errors++; $display("FAIL midrst_sample: got %0d expected 0", bus0.sample_out); end
        if (bus0.symbol !== 2'b00) begin errors++; $display("FAIL midrst_symbol: got %b expected 00", bus0.symbol); end
        if (bus0.sym_strobe !== 1'b0) begin errors++; $display("FAIL midrst_strobe: got %b expected 0", bus0.sym_strobe); end
        if (bus0.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", bus0.busy); end
        if (bus0.phase_err !== 1'b0) begin errors++; $display("FAIL midrst_phase_err: got %b expected 0", bus0.phase_err); end
        reset = 1'b1;
        wait_sym();
        checks += 2;
        if (bus0.symbol !== 2'b10) begin errors++; $display("FAIL midrst_restart_symbol: got %b expected 10", bus0.symbol); end
        if (bus0.sample_out !== P3) begin errors++; $display("FAIL midrst_restart_sample: got %0d expected %0d", bus0.sample_out, P3); end
    endtask
    initial begin
        reset = 1'b0;
        bus0.run = 1'b0;
        bus1.run = 1'b0;
        bus0.sam_clk_ena = 1'b0;
        bus0.sym_clk_ena = 1'b0;
        bus1.sam_clk_ena = 1'b0;
        bus1.sym_clk_ena = 1'b0;
        test_reset();
        test_hold();
        test_preamble();
        test_payload();
        test_stop_restart();
        test_strobe_fault();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
